// File: rtl/test_port_capture.sv
// test_port_capture: turns CPU stores to the test-port address into a
// one-word-per-store stream, framed between BEGIN_SYM and END_SYM, and
// buffers it in a small valid/ready FIFO.
// Optional feature macro: TPC_BYTESWAP_EN (byte-swap bus data into readable
// order before symbol compare and push). Undefined: data is used unmodified.
module test_port_capture #(
  parameter logic [29:0] TEST_ADDR  = 30'h10,
  parameter logic [31:0] BEGIN_SYM  = 32'h00000168,
  parameter logic [31:0] END_SYM    = 32'hFFFFFD5D,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  word_count,
  output logic        overflow,
  output logic        session_active,
  output logic        session_done,
  output logic        drained
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {E_ARMED, E_HELD} edge_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sess_t;

  edge_t edge_q, edge_d;
  sess_t sess_q, sess_d;

  logic [31:0] word;
  logic        cap;
  logic        push_req;
  logic        begin_hit;
  logic        push;
  logic        pop;
  logic        drop;
  logic        empty;
  logic        full;

  logic [DEPTH_LOG2:0] wr_q, rd_q;
  logic [31:0]         mem_q [DEPTH];
  logic [7:0]          word_count_q;
  logic                overflow_q;

`ifdef TPC_BYTESWAP_EN
  assign word = {data[7:0], data[15:8], data[23:16], data[31:24]};
`else
  assign word = data;
`endif

  // Edge FSM state register
  always_ff @(posedge clk) begin
    if (!rst) edge_q <= E_ARMED;
    else      edge_q <= edge_d;
  end

  // Edge FSM next state: any write (any address) holds off further captures until wen drops
  always_comb begin
    edge_d = wen ? E_HELD : E_ARMED;
  end

  // Edge FSM output: one capture strobe per rising write enable at the test port
  always_comb begin
    cap = (edge_q == E_ARMED) && wen && (addr == TEST_ADDR);
  end

  // Session FSM state register
  always_ff @(posedge clk) begin
    if (!rst) sess_q <= S_IDLE;
    else      sess_q <= sess_d;
  end

  // Session FSM next state: IDLE -> RUN on begin symbol, RUN -> DONE on end symbol
  always_comb begin
    sess_d = sess_q;
    unique case (sess_q)
      S_IDLE:  if (cap && word == BEGIN_SYM) sess_d = S_RUN;
      S_RUN:   if (cap && word == END_SYM)   sess_d = S_DONE;
      S_DONE:  sess_d = S_DONE;
      default: sess_d = S_IDLE;
    endcase
  end

  // Session FSM outputs: push requests only while running; begin clears the word count
  always_comb begin
    push_req       = cap && (sess_q == S_RUN);
    begin_hit      = cap && (sess_q == S_IDLE) && (word == BEGIN_SYM);
    session_active = (sess_q == S_RUN);
    session_done   = (sess_q == S_DONE);
  end

  // FIFO status; a push into a full FIFO is still accepted when the head pops in the same cycle
  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
            (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
    pop   = !empty && out_ready;
    push  = push_req && (!full || pop);
    drop  = push_req && full && !pop;
  end

  // FIFO pointers, word counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q         <= '0;
      rd_q         <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (begin_hit)
        word_count_q <= '0;
      else if (push && word_count_q != 8'hFF)
        word_count_q <= word_count_q + 8'd1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since out_data is gated by out_valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= word;
  end

  // Output drive
  always_comb begin
    out_valid  = !empty;
    out_data   = empty ? 32'h0 : mem_q[rd_q[DEPTH_LOG2-1:0]];
    word_count = word_count_q;
    overflow   = overflow_q;
    drained    = session_done && empty;
  end

endmodule
